// File: rtl/m_mem_access.sv
// ---------------------------------------------------------------------------
// m_mem_access
//
// M-stage memory access controller. Sits directly upstream of the
// load-extension / AdEL stage.
//   * Checks store addresses against the data memory / timer map and raises
//     AdES combinationally.
//   * Builds byte strobes and lane-replicated write data for SW/SH/SB.
//   * Issues one req/ready bus transaction per live memory instruction and
//     stalls F/D/E/M until it completes (IDLE -> BUSY -> DONE).
//   * Registers the raw read word (or_rdata), flagged by o_rdata_valid for
//     the single DONE cycle of the instruction that produced it.
//
// Optional feature macro: MEM_TIMEOUT_EN
//   defined   : BUSY gives up after TIMEOUT_CYCLES cycles without ready,
//               returns a zero read word and pulses o_bus_err in DONE.
//   undefined : BUSY waits indefinitely, o_bus_err is tied low.
//
// Ports
//   i_clk, i_reset          clock, asynchronous active-high reset
//   i_valid/i_load/i_store  live M-stage instruction and its kind
//   i_stOp                  store width (0 SW, 1 SH, 2 SB)
//   i_Addr, i_wdata         effective address, store source value
//   i_exc_DMOv              address-calculation overflow
//   i_kill                  instruction flushed / already excepted
//   o_stall                 freeze F/D/E/M
//   or_rdata, o_rdata_valid registered raw read word and its valid flag
//   o_exc_AdES              store address exception (combinational)
//   o_bus_*                 request-side bus signals (held stable in BUSY)
//   i_bus_ready/i_bus_rdata slave completion and read data
//   o_bus_err               timeout pulse in DONE
// ---------------------------------------------------------------------------
module m_mem_access #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_valid,
    input  logic        i_load,
    input  logic        i_store,
    input  logic [1:0]  i_stOp,
    input  logic [31:0] i_Addr,
    input  logic [31:0] i_wdata,
    input  logic        i_exc_DMOv,
    input  logic        i_kill,
    output logic        o_stall,
    output logic [31:0] or_rdata,
    output logic        o_rdata_valid,
    output logic        o_exc_AdES,
    output logic        o_bus_req,
    output logic        o_bus_we,
    output logic [31:0] o_bus_addr,
    output logic [3:0]  o_bus_wstrb,
    output logic [31:0] o_bus_wdata,
    input  logic        i_bus_ready,
    input  logic [31:0] i_bus_rdata,
    output logic        o_bus_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_reg;
    state_t state_next;

    // ------------------------------------------------------------------
    // Store address checking
    // ------------------------------------------------------------------
    logic is_sh;
    logic is_sb;
    logic is_sw;
    logic in_dm;
    logic in_tc0;
    logic in_tc1;
    logic misaligned;
    logic narrow_io;
    logic count_reg_hit;
    logic start;

    assign is_sh = (i_stOp == 2'd1);
    assign is_sb = (i_stOp == 2'd2);
    // Encoding 3 is unused; it falls back to word behaviour.
    assign is_sw = !is_sh && !is_sb;

    assign in_dm  = (i_Addr <= 32'h0000_2FFF);
    assign in_tc0 = (i_Addr >= 32'h0000_7F00) && (i_Addr <= 32'h0000_7F0B);
    assign in_tc1 = (i_Addr >= 32'h0000_7F10) && (i_Addr <= 32'h0000_7F1B);

    assign misaligned    = (is_sw && (i_Addr[1:0] != 2'b00)) || (is_sh && i_Addr[0]);
    // Timer registers only accept full-word stores.
    assign narrow_io     = !is_sw && (i_Addr >= 32'h0000_7F00);
    // COUNT registers are read-only.
    assign count_reg_hit = (i_Addr == 32'h0000_7F08) || (i_Addr == 32'h0000_7F18);

    assign o_exc_AdES = i_store && i_valid &&
                        (misaligned || !(in_dm || in_tc0 || in_tc1) ||
                         narrow_io || count_reg_hit || i_exc_DMOv);

    assign start = i_valid && (i_load || i_store) && !i_kill && !o_exc_AdES;

    // ------------------------------------------------------------------
    // Strobes and lane-replicated write data
    // ------------------------------------------------------------------
    logic [3:0]  store_strb;
    logic [31:0] store_data;

    always_comb begin
        store_strb = 4'b1111;
        store_data = i_wdata;
        if (is_sh) begin
            store_strb = i_Addr[1] ? 4'b1100 : 4'b0011;
            store_data = {2{i_wdata[15:0]}};
        end else if (is_sb) begin
            store_strb = 4'b0001 << i_Addr[1:0];
            store_data = {4{i_wdata[7:0]}};
        end
    end

    // ------------------------------------------------------------------
    // Optional bus timeout
    // ------------------------------------------------------------------
    logic expire;

`ifdef MEM_TIMEOUT_EN
    localparam int CW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [CW-1:0] wait_cnt_reg;

    // Expiry is only declared when ready is absent: a late ready wins.
    assign expire = (state_reg == BUSY) && !i_bus_ready &&
                    (wait_cnt_reg == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            wait_cnt_reg <= '0;
        end else if (state_reg != BUSY) begin
            // Holds zero outside BUSY, so every BUSY entry starts from zero.
            wait_cnt_reg <= '0;
        end else if (!i_bus_ready) begin
            wait_cnt_reg <= wait_cnt_reg + 1'b1;
        end
    end
`else
    logic unused_timeout;

    assign expire         = 1'b0;
    assign unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        o_stall    = 1'b0;
        o_bus_req  = 1'b0;
        case (state_reg)
            IDLE: begin
                o_stall = start;
                if (start) begin
                    state_next = BUSY;
                end
            end
            BUSY: begin
                o_stall   = 1'b1;
                o_bus_req = 1'b1;
                if (i_bus_ready || expire) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                // Pipeline advances on this edge; the instruction never restarts.
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Bus request registers, read word, status pulses
    // ------------------------------------------------------------------
    logic        we_reg;
    logic [31:0] addr_reg;
    logic [3:0]  wstrb_reg;
    logic [31:0] wdata_reg;
    logic [31:0] rdata_reg;
    logic        rdata_valid_reg;
    logic        bus_err_reg;
    logic        kill_reg;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            we_reg          <= 1'b0;
            addr_reg        <= 32'h0;
            wstrb_reg       <= 4'b0000;
            wdata_reg       <= 32'h0;
            rdata_reg       <= 32'h0;
            rdata_valid_reg <= 1'b0;
            bus_err_reg     <= 1'b0;
            kill_reg        <= 1'b0;
        end else begin
            rdata_valid_reg <= 1'b0;
            bus_err_reg     <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        we_reg    <= i_store;
                        addr_reg  <= {i_Addr[31:2], 2'b00};
                        wstrb_reg <= i_store ? store_strb : 4'b0000;
                        wdata_reg <= i_store ? store_data : 32'h0;
                        kill_reg  <= 1'b0;
                    end
                end
                BUSY: begin
                    // A kill cannot abort the bus cycle; remember it so the
                    // result is not flagged valid for a flushed instruction.
                    if (i_kill) begin
                        kill_reg <= 1'b1;
                    end
                    if (i_bus_ready) begin
                        if (!we_reg) begin
                            rdata_reg <= i_bus_rdata;
                        end
                        rdata_valid_reg <= !(kill_reg || i_kill);
                    end else if (expire) begin
                        rdata_reg       <= 32'h0;
                        bus_err_reg     <= 1'b1;
                        rdata_valid_reg <= !(kill_reg || i_kill);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_bus_we      = we_reg;
    assign o_bus_addr    = addr_reg;
    assign o_bus_wstrb   = wstrb_reg;
    assign o_bus_wdata   = wdata_reg;
    assign or_rdata      = rdata_reg;
    assign o_rdata_valid = rdata_valid_reg;
    assign o_bus_err     = bus_err_reg;

endmodule

// File: tb/tb_m_mem_access.sv
// ---------------------------------------------------------------------------
// tb_m_mem_access
//
// Table of directed memory instructions plus randomized transactions, each
// run through a bench-side bus slave and compared with a reference model of
// the address map, strobe/lane rules and handshake timing. Hand-written
// sequences cover asynchronous reset mid-transaction, i_valid low, and the
// bus timeout (only when MEM_TIMEOUT_EN is defined).
// ---------------------------------------------------------------------------
module tb_m_mem_access;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_valid;
    logic        i_load;
    logic        i_store;
    logic [1:0]  i_stOp;
    logic [31:0] i_Addr;
    logic [31:0] i_wdata;
    logic        i_exc_DMOv;
    logic        i_kill;
    logic        o_stall;
    logic [31:0] or_rdata;
    logic        o_rdata_valid;
    logic        o_exc_AdES;
    logic        o_bus_req;
    logic        o_bus_we;
    logic [31:0] o_bus_addr;
    logic [3:0]  o_bus_wstrb;
    logic [31:0] o_bus_wdata;
    logic        i_bus_ready;
    logic [31:0] i_bus_rdata;
    logic        o_bus_err;

    always #5 clk = ~clk;

    m_mem_access #(.TIMEOUT_CYCLES(TMO)) dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_valid      (i_valid),
        .i_load       (i_load),
        .i_store      (i_store),
        .i_stOp       (i_stOp),
        .i_Addr       (i_Addr),
        .i_wdata      (i_wdata),
        .i_exc_DMOv   (i_exc_DMOv),
        .i_kill       (i_kill),
        .o_stall      (o_stall),
        .or_rdata     (or_rdata),
        .o_rdata_valid(o_rdata_valid),
        .o_exc_AdES   (o_exc_AdES),
        .o_bus_req    (o_bus_req),
        .o_bus_we     (o_bus_we),
        .o_bus_addr   (o_bus_addr),
        .o_bus_wstrb  (o_bus_wstrb),
        .o_bus_wdata  (o_bus_wdata),
        .i_bus_ready  (i_bus_ready),
        .i_bus_rdata  (i_bus_rdata),
        .o_bus_err    (o_bus_err)
    );

    int          vectors     = 0;
    int          miscompares = 0;
    int          txn_no      = 0;
    logic [31:0] model_rdata = 32'h0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int m_size(input logic [1:0] op);
        if (op == 2'd1) return 2;
        if (op == 2'd2) return 1;
        return 4;
    endfunction

    function automatic logic m_ades(input logic v, input logic st, input logic [1:0] op,
                                    input logic [31:0] a, input logic ov);
        int  size;
        bit  in_map;
        bit  mis;
        bit  narrow;
        bit  cnt;
        size   = m_size(op);
        in_map = (a <= 32'h2FFF) || (a >= 32'h7F00 && a <= 32'h7F0B) ||
                 (a >= 32'h7F10 && a <= 32'h7F1B);
        mis    = ((a % size) != 0);
        narrow = (size < 4) && (a >= 32'h7F00);
        cnt    = (a == 32'h7F08) || (a == 32'h7F18);
        return v && st && (mis || !in_map || narrow || cnt || ov);
    endfunction

    function automatic logic [3:0] m_strb(input logic st, input logic [1:0] op, input logic [31:0] a);
        int         size;
        int         base;
        logic [3:0] s;
        size = m_size(op);
        base = int'(a[1:0]) - (int'(a[1:0]) % size);
        s    = 4'b0000;
        for (int b = 0; b < 4; b++) begin
            s[b] = st && (b >= base) && (b < base + size);
        end
        return s;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [1:0] op, input logic [31:0] wd);
        int          size;
        logic [31:0] w;
        size = m_size(op);
        w    = 32'h0;
        for (int b = 0; b < 4; b++) begin
            w[8*b +: 8] = wd[8*(b % size) +: 8];
        end
        return w;
    endfunction

    // ---------------- one instruction through the stage ----------------
    // ready_on: BUSY cycle (1-based) where the slave answers, 0 = never.
    // kill_on : BUSY cycle with an i_kill pulse, -1 = killed at issue.
    task automatic run_txn(input logic ld, input logic st, input logic [1:0] op,
                           input logic [31:0] addr, input logic [31:0] wd, input logic dmov,
                           input int ready_on, input logic [31:0] rd, input int kill_on,
                           input logic exp_ades, input logic [3:0] exp_strb,
                           input logic [31:0] exp_wdata);
        logic        exp_start;
        logic        exp_err;
        logic        exp_valid;
        logic [31:0] exp_rd;
        int          exp_busy;
        int          stall_cnt;
        int          busy;
        bit          done;
        txn_no++;
        @(negedge clk);
        i_valid     = 1'b1;
        i_load      = ld;
        i_store     = st;
        i_stOp      = op;
        i_Addr      = addr;
        i_wdata     = wd;
        i_exc_DMOv  = dmov;
        i_kill      = (kill_on < 0);
        i_bus_ready = 1'b0;
        #1;
        chk("ades", 64'(o_exc_AdES), 64'(exp_ades));
        exp_start = (ld || st) && !exp_ades && (kill_on >= 0);
        if (!exp_start) begin
            for (int c = 0; c < 3; c++) begin
                chk("no_req_no_stall", 64'({o_bus_req, o_stall}), 64'(0));
                @(negedge clk);
                #1;
            end
            i_valid    = 1'b0;
            i_kill     = 1'b0;
            i_exc_DMOv = 1'b0;
            $display("txn %0d: ld=%0d st=%0d op=%0d addr=%08h -> no transaction (ades=%0d)",
                     txn_no, ld, st, op, addr, o_exc_AdES);
        end else begin
            exp_err  = 1'b0;
            exp_busy = ready_on;
`ifdef MEM_TIMEOUT_EN
            if (ready_on == 0 || ready_on > TMO) begin
                exp_busy = TMO;
                exp_err  = 1'b1;
            end
`endif
            exp_valid = !(kill_on >= 1 && kill_on <= exp_busy);
            if (exp_err)        exp_rd = 32'h0;
            else if (!st)       exp_rd = rd;
            else                exp_rd = model_rdata;
            stall_cnt = 0;
            busy      = 0;
            done      = 0;
            for (int c = 0; c < 60 && !done; c++) begin
                if (c > 0 && !o_stall) begin
                    done = 1;
                    chk("stall_cycles", 64'(stall_cnt), 64'(exp_busy + 1));
                    chk("busy_cycles", 64'(busy), 64'(exp_busy));
                    chk("rdata", 64'(or_rdata), 64'(exp_rd));
                    chk("rdata_valid", 64'(o_rdata_valid), 64'(exp_valid));
                    chk("bus_err", 64'(o_bus_err), 64'(exp_err));
                    chk("req_in_done", 64'(o_bus_req), 64'(0));
                    i_valid     = 1'b0;
                    i_kill      = 1'b0;
                    i_bus_ready = 1'b0;
                    i_exc_DMOv  = 1'b0;
                end else begin
                    if (c == 0) chk("issue_stall_noreq", 64'({o_stall, o_bus_req}), 64'(2'b10));
                    if (o_stall) stall_cnt++;
                    i_kill      = 1'b0;
                    i_bus_ready = 1'b0;
                    i_bus_rdata = $urandom;
                    if (o_bus_req) begin
                        busy++;
                        chk("bus_we_strb_addr", 64'({o_bus_we, o_bus_wstrb, o_bus_addr}),
                            64'({st, exp_strb, addr[31:2], 2'b00}));
                        if (st) chk("bus_wdata", 64'(o_bus_wdata), 64'(exp_wdata));
                        if (busy == kill_on) i_kill = 1'b1;
                        if (busy == ready_on) begin
                            i_bus_ready = 1'b1;
                            i_bus_rdata = rd;
                        end
                    end
                    @(negedge clk);
                    #1;
                end
            end
            if (!done) chk("done_reached", 64'(0), 64'(1));
            @(negedge clk);
            #1;
            chk("after_done_quiet", 64'({o_rdata_valid, o_bus_req, o_bus_err, o_stall}), 64'(0));
            model_rdata = exp_rd;
            $display("txn %0d: ld=%0d st=%0d op=%0d addr=%08h strb=%b busy=%0d rdata=%08h err=%0d",
                     txn_no, ld, st, op, addr, exp_strb, busy, or_rdata, exp_err);
        end
    endtask

    typedef struct {
        logic        ld;
        logic        st;
        logic [1:0]  op;
        logic [31:0] addr;
        logic [31:0] wd;
        logic        dmov;
        int          ready_on;
        logic [31:0] rd;
        int          kill_on;
        logic        exp_ades;
        logic [3:0]  exp_strb;
        logic [31:0] exp_wdata;
    } vec_t;

    function automatic vec_t mk(input logic ld, input logic st, input logic [1:0] op,
                                input logic [31:0] addr, input logic [31:0] wd, input logic dmov,
                                input int ready_on, input logic [31:0] rd, input int kill_on,
                                input logic ea, input logic [3:0] es, input logic [31:0] ew);
        vec_t v;
        v.ld = ld; v.st = st; v.op = op; v.addr = addr; v.wd = wd; v.dmov = dmov;
        v.ready_on = ready_on; v.rd = rd; v.kill_on = kill_on;
        v.exp_ades = ea; v.exp_strb = es; v.exp_wdata = ew;
        return v;
    endfunction

    vec_t tbl[21];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got hang, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //              ld st op addr          wd            ov rdy rd            kill ades strb   wdata
        tbl[0]  = mk(0, 1, 0, 32'h0000_0010, 32'hDEADBEEF, 0, 1, 32'h0,        0, 0, 4'hF, 32'hDEADBEEF);
        tbl[1]  = mk(0, 1, 2, 32'h0000_0013, 32'h000000A5, 0, 1, 32'h0,        0, 0, 4'h8, 32'hA5A5A5A5);
        tbl[2]  = mk(0, 1, 1, 32'h0000_0002, 32'h00001234, 0, 1, 32'h0,        0, 0, 4'hC, 32'h12341234);
        tbl[3]  = mk(1, 0, 0, 32'h0000_0100, 32'h0,        0, 3, 32'h89ABCDEF, 0, 0, 4'h0, 32'h0);
        tbl[4]  = mk(0, 1, 0, 32'h0000_0002, 32'h1,        0, 1, 32'h0,        0, 1, 4'h0, 32'h0);
        tbl[5]  = mk(0, 1, 1, 32'h0000_0001, 32'h1,        0, 1, 32'h0,        0, 1, 4'h0, 32'h0);
        tbl[6]  = mk(0, 1, 2, 32'h0000_7F00, 32'h1,        0, 1, 32'h0,        0, 1, 4'h0, 32'h0);
        tbl[7]  = mk(0, 1, 0, 32'h0000_7F08, 32'h1,        0, 1, 32'h0,        0, 1, 4'h0, 32'h0);
        tbl[8]  = mk(0, 1, 0, 32'h0000_3000, 32'h1,        0, 1, 32'h0,        0, 1, 4'h0, 32'h0);
        tbl[9]  = mk(0, 1, 0, 32'h0000_7F04, 32'h11223344, 0, 2, 32'h0,        0, 0, 4'hF, 32'h11223344);
        tbl[10] = mk(0, 1, 0, 32'h0000_7F18, 32'h1,        0, 1, 32'h0,        0, 1, 4'h0, 32'h0);
        tbl[11] = mk(0, 1, 0, 32'h0000_7F1C, 32'h1,        0, 1, 32'h0,        0, 1, 4'h0, 32'h0);
        tbl[12] = mk(0, 1, 0, 32'h0000_7F0C, 32'h1,        0, 1, 32'h0,        0, 1, 4'h0, 32'h0);
        tbl[13] = mk(0, 1, 0, 32'h0000_0010, 32'h1,        1, 1, 32'h0,        0, 1, 4'h0, 32'h0);
        tbl[14] = mk(0, 1, 2, 32'h0000_2FFF, 32'h0000003C, 0, 1, 32'h0,        0, 0, 4'h8, 32'h3C3C3C3C);
        tbl[15] = mk(0, 1, 1, 32'h0000_2FFE, 32'h0000BEEF, 0, 2, 32'h0,        0, 0, 4'hC, 32'hBEEFBEEF);
        tbl[16] = mk(1, 0, 0, 32'h0000_3000, 32'h0,        0, 1, 32'h13572468, 0, 0, 4'h0, 32'h0);
        tbl[17] = mk(1, 0, 0, 32'h0000_0200, 32'h0,        0, 3, 32'hCAFEF00D, 2, 0, 4'h0, 32'h0);
        tbl[18] = mk(1, 0, 0, 32'h0000_0300, 32'h0,        0, 1, 32'h77777777,-1, 0, 4'h0, 32'h0);
        tbl[19] = mk(0, 1, 0, 32'h0000_7F14, 32'h0BADF00D, 0, 1, 32'h0,        0, 0, 4'hF, 32'h0BADF00D);
        tbl[20] = mk(0, 1, 1, 32'h0000_7F10, 32'h1,        0, 1, 32'h0,        0, 1, 4'h0, 32'h0);

        rst         = 1'b1;
        i_valid     = 1'b0;
        i_load      = 1'b0;
        i_store     = 1'b0;
        i_stOp      = 2'd0;
        i_Addr      = 32'h0;
        i_wdata     = 32'h0;
        i_exc_DMOv  = 1'b0;
        i_kill      = 1'b0;
        i_bus_ready = 1'b0;
        i_bus_rdata = 32'h0;
        #1;
        chk("reset_ctrl", 64'({o_bus_req, o_bus_we, o_bus_wstrb, o_rdata_valid, o_bus_err, o_stall}), 64'(0));
        chk("reset_rdata", 64'(or_rdata), 64'(0));
        chk("reset_addr_wdata", {o_bus_addr, o_bus_wdata}, 64'(0));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Directed table.
        for (int i = 0; i < 21; i++) begin
            run_txn(tbl[i].ld, tbl[i].st, tbl[i].op, tbl[i].addr, tbl[i].wd, tbl[i].dmov,
                    tbl[i].ready_on, tbl[i].rd, tbl[i].kill_on,
                    tbl[i].exp_ades, tbl[i].exp_strb, tbl[i].exp_wdata);
        end

        // A store to an illegal address with i_valid low raises nothing.
        @(negedge clk);
        i_valid = 1'b0; i_store = 1'b1; i_stOp = 2'd0; i_Addr = 32'h0000_0002;
        #1;
        chk("ades_needs_valid", 64'({o_exc_AdES, o_stall, o_bus_req}), 64'(0));
        i_store = 1'b0;

        // Asynchronous reset in the middle of a BUSY load.
        @(negedge clk);
        i_valid = 1'b1; i_load = 1'b1; i_store = 1'b0; i_Addr = 32'h0000_0040; i_bus_ready = 1'b0;
        @(negedge clk);
        #1;
        chk("busy_before_reset", 64'(o_bus_req), 64'(1));
        chk("rdata_before_reset", 64'(or_rdata), 64'(model_rdata));
        rst = 1'b1;
        #1;
        chk("reset_drops_req", 64'({o_bus_req, o_rdata_valid, o_bus_err}), 64'(0));
        chk("reset_clears_rdata", 64'(or_rdata), 64'(0));
        chk("reset_clears_addr", 64'(o_bus_addr), 64'(0));
        i_valid = 1'b0; i_load = 1'b0;
        model_rdata = 32'h0;
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            chk("idle_after_reset", 64'({o_bus_req, o_stall, o_rdata_valid}), 64'(0));
        end
        $display("txn reset-mid-busy: request dropped, state back to idle");

`ifdef MEM_TIMEOUT_EN
        // Ready never arrives: gives up after TMO BUSY cycles with an error.
        run_txn(1, 0, 0, 32'h0000_0080, 32'h0, 0, 0, 32'hFFFF0000, 0, 0, 4'h0, 32'h0);
        // Ready on the last allowed cycle beats the timeout.
        run_txn(1, 0, 0, 32'h0000_0084, 32'h0, 0, TMO, 32'h600DF00D, 0, 0, 4'h0, 32'h0);
`endif

        // Randomized transactions against the model.
        for (int n = 0; n < 40; n++) begin
            logic        r_st;
            logic [1:0]  r_op;
            logic [31:0] r_a;
            logic [31:0] r_wd;
            logic [31:0] r_rd;
            logic        r_ov;
            int          r_ready;
            int          r_kill;
            int          sel;
            r_st = 1'($urandom_range(0, 1));
            r_op = 2'($urandom_range(0, 2));
            sel  = int'($urandom_range(0, 3));
            case (sel)
                0:       r_a = $urandom_range(0, 32'h2FFF);
                1:       r_a = 32'h7F00 + $urandom_range(0, 31);
                2:       r_a = 32'h2FF0 + $urandom_range(0, 32'h30);
                default: r_a = $urandom;
            endcase
            r_wd    = $urandom;
            r_rd    = $urandom;
            r_ov    = ($urandom_range(0, 9) == 0);
            r_ready = int'($urandom_range(1, 4));
            r_kill  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 4)) : 0;
            run_txn(!r_st, r_st, r_op, r_a, r_wd, r_ov, r_ready, r_rd, r_kill,
                    m_ades(1'b1, r_st, r_op, r_a, r_ov), m_strb(r_st, r_op, r_a),
                    m_wdata(r_op, r_wd));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
